// File: rtl/key_encoder_pkg.sv
// Shared constants, FSM state type and priority encoder for the 8-to-3 key encoder.
package key_encoder_pkg;

    localparam int KEY_NUM = 8;
    localparam int CODE_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Highest set index wins; all-zero input encodes to 0.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [KEY_NUM-1:0] keys);
        prio_enc = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (keys[i]) prio_enc = CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, stability counter and debounced level flop.
// A level change is accepted after DB_CYCLES consecutive differing synchronized samples.
module key_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic key
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Toggling on the increment that would reach DB_CYCLES keeps key and clear in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            key   <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 == key) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_encoder_8_3.sv
// Debounced 8-key priority encoder with press strobe; optional MULTI output
// enabled by macro KEY_ENCODER_MULTI_ERR_EN.
module key_encoder_8_3
    import key_encoder_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_NUM-1:0]  SW,
    output logic [CODE_W-1:0]   CODE,
    output logic                STROBE,
    output logic                ANY_KEY,
    output logic [KEY_NUM-1:0]  KEYS
`ifdef KEY_ENCODER_MULTI_ERR_EN
    ,
    output logic                MULTI
`endif
);

    logic [KEY_NUM-1:0] keys_d;
    logic               press;
    state_t             state;
    state_t             state_nxt;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .sw  (SW[i]),
            .key (KEYS[i])
        );
    end

    // Any rising debounced key in this cycle is one press, however many rose together.
    assign press = |(KEYS & ~keys_d);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (press)        state_nxt = HELD;
            HELD:    if (KEYS == '0)   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_d <= '0;
            STROBE <= 1'b0;
            CODE   <= '0;
            state  <= IDLE;
        end else begin
            keys_d <= KEYS;
            STROBE <= press;
            state  <= state_nxt;
            if (press) CODE <= prio_enc(KEYS);
        end
    end

    assign ANY_KEY = (state == HELD);

`ifdef KEY_ENCODER_MULTI_ERR_EN
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MULTI <= 1'b0;
        end else begin
            MULTI <= |(KEYS & (KEYS - KEY_NUM'(1)));
        end
    end
`endif

endmodule

// File: doc/key_encoder_8_3.md
KEY_ENCODER_8_3 -- requirements
Module: key_encoder_8_3

Interface
REQ-001 The block SHALL have one clock, `clk`; reset `rst` SHALL be asynchronous and active-high.
REQ-002 Parameter `DB_CYCLES`, default 1000000, SHALL be the number of consecutive stable synchronized samples needed to accept a key level change; legal range is 1 to 2^24-1.
REQ-003 Port `clk`, input, 1 bit: system clock.
REQ-004 Port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-005 Port `SW`, input, 8 bits: raw asynchronous key/switch levels, 1 = pressed.
REQ-006 Port `CODE`, output, 3 bits: registered binary index of the highest pressed key, captured at the last strobe.
REQ-007 Port `STROBE`, output, 1 bit: one-cycle pulse marking a new debounced press.
REQ-008 Port `ANY_KEY`, output, 1 bit: registered OR of all debounced key levels.
REQ-009 Port `KEYS`, output, 8 bits: registered debounced key levels.

Function
REQ-010 Each `SW[i]` SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each key SHALL have a debounce counter, `$clog2(DB_CYCLES+1)` bits wide.
REQ-012 The counter SHALL clear whenever the synchronized sample equals `KEYS[i]`, and SHALL increment otherwise.
REQ-013 When the counter reaches `DB_CYCLES`, `KEYS[i]` SHALL toggle to the synchronized value and the counter SHALL clear in the same cycle.
REQ-014 A glitch shorter than `DB_CYCLES` synchronized cycles SHALL NOT change `KEYS`; the counter restarts from 0 on each bounce.
REQ-015 A press event SHALL be any `KEYS[i]` 0->1 transition.
REQ-016 On a press event, `STROBE` SHALL be 1 for exactly one cycle, on the cycle after `KEYS` changes.
REQ-017 In that same cycle, `CODE` SHALL load the priority encoding of the new `KEYS`, with the highest index winning.
REQ-018 `CODE` SHALL hold its value between strobes, including after all keys are released.
REQ-019 Release transitions (1->0) SHALL NOT generate `STROBE`.
REQ-020 If several keys become debounced in the same cycle, exactly one `STROBE` SHALL be produced, and `CODE` SHALL be the highest index.
REQ-021 If a lower-index key is pressed while a higher-index key is held, `STROBE` SHALL fire and `CODE` SHALL remain the higher index.
REQ-022 Press latency SHALL be exactly `DB_CYCLES + 3` clock edges, from the first edge that samples the new stable level to `STROBE` high.
REQ-023 The control FSM SHALL have states IDLE (`KEYS == 0`) and HELD (`KEYS != 0`).
REQ-024 The FSM SHALL go IDLE->HELD on the first press event and HELD->IDLE when `KEYS` returns to 0.
REQ-025 `ANY_KEY` SHALL be 1 exactly in state HELD.

Reset
REQ-026 While `rst` is high, the following SHALL all be 0: synchronizer flops, counters, `KEYS`, `CODE` (3'b000), `STROBE`, and `ANY_KEY`; the FSM SHALL be in IDLE.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count.
REQ-028 After reset release, keys already held SHALL be debounced afresh and SHALL produce a `STROBE`.

Configuration
REQ-029 With macro `KEY_ENCODER_MULTI_ERR_EN` defined, the block SHALL add output `MULTI`, 1 bit, reset 0.
REQ-030 `MULTI` SHALL be registered and SHALL be 1 while two or more `KEYS` bits are 1.
REQ-031 `MULTI` SHALL update in the same cycle as `ANY_KEY`.
REQ-032 Without the macro, port `MULTI` and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package `key_encoder_pkg` SHALL hold `KEY_NUM = 8`, `CODE_W = 3`, the FSM state typedef {IDLE, HELD}, and the priority-encode function.
REQ-034 Sub-module `key_debounce` (synchronizer + counter + debounced flop, parameter `DB_CYCLES`) SHALL be instantiated 8 times.

Verification (bench `DB_CYCLES = 4`)
REQ-035 Reset, then `SW = 8'h00` held -> `CODE = 0`, `STROBE = 0`, `ANY_KEY = 0`, and `KEYS = 0` for 50 cycles.
REQ-036 `SW[5]` rises and is held -> `STROBE` pulses once, 7 edges later, with `CODE = 3'd5` and `ANY_KEY = 1`; `SW[5]` released -> `ANY_KEY = 0` after 7 edges, no `STROBE`, `CODE` stays 5.
REQ-037 `SW[2]` toggles 1,0,1,0 on alternate cycles, then stays 0 -> `KEYS[2]` never rises and `STROBE` never asserts.
REQ-038 `SW` goes from 8'h00 to 8'h81 on one edge -> a single `STROBE` with `CODE = 3'd7`; with `KEY_ENCODER_MULTI_ERR_EN`, `MULTI = 1` with `ANY_KEY`.
REQ-039 `SW[6]` is held, then `SW[1]` is pressed -> a second `STROBE` with `CODE = 3'd6`.
REQ-040 `SW[3]` is held and `rst` is pulsed 2 cycles after the edge -> all outputs are 0 during reset; after release, `STROBE` fires 7 edges later with `CODE = 3'd3`.
